// File: rtl/riscv_crypto_sha256_msched.sv
// ---------------------------------------------------------------------------
// riscv_crypto_sha256_msched
//
// SHA-256 message-schedule expander. It takes one 512-bit block as 16
// streamed 32-bit words W0..W15, then emits the full 64-word schedule
// W0..W63. W16..W63 are generated on the fly from a sliding 16-word window
// using the SHA-256 small-sigma functions.
//
// Ports
//   g_clk      in   1  clock, rising edge
//   g_resetn   in   1  asynchronous active-low reset
//   flush      in   1  synchronous abort back to LOAD (wins over handshakes)
//   in_valid   in   1  in_word is valid
//   in_ready   out  1  high in LOAD
//   in_word    in  32  message word, W0 first
//   out_valid  out  1  high in EMIT
//   out_ready  in   1  consumer accepts out_word
//   out_word   out 32  schedule word W[out_idx]
//   out_idx    out  6  schedule index 0..63
//   out_last   out  1  high with out_valid at index 63
//   busy       out  1  high unless idle in LOAD with no words loaded
// ---------------------------------------------------------------------------
module riscv_crypto_sha256_msched (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_idx,
    output logic        out_last,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // SHA-256 small sigma 0: ROR7 ^ ROR18 ^ SHR3
    function automatic logic [31:0] sig0(input logic [31:0] x);
        sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // SHA-256 small sigma 1: ROR17 ^ ROR19 ^ SHR10
    function automatic logic [31:0] sig1(input logic [31:0] x);
        sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    state_t      r_state;
    logic [3:0]  r_lc;
    logic [5:0]  r_ec;
    logic [31:0] r_win [16];

    state_t      w_state_nxt;
    logic [3:0]  w_lc_nxt;
    logic [5:0]  w_ec_nxt;
    logic        w_emit;
    logic        w_in_hs;
    logic        w_out_hs;
    logic [31:0] w_new;

    assign w_emit   = (r_state == ST_EMIT);
    // flush suppresses both handshakes so the window is never touched by
    // a transfer that is being aborted.
    assign w_in_hs  = in_valid  && !w_emit && !flush;
    assign w_out_hs = out_ready &&  w_emit && !flush;

    // Window holds W[ec..ec+15], so this is W[ec+16].
    assign w_new = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    // Outputs are decoded from registered state only; gating with EMIT
    // keeps out_word/out_idx at zero whenever nothing is offered.
    assign in_ready  = !w_emit;
    assign out_valid = w_emit;
    assign out_word  = w_emit ? r_win[0] : 32'h0000_0000;
    assign out_idx   = w_emit ? r_ec : 6'd0;
    assign out_last  = w_emit && (r_ec == 6'd63);
    assign busy      = !((r_state == ST_LOAD) && (r_lc == 4'd0));

    // Next-state decode for state, load count and emit count.
    always_comb begin
        w_state_nxt = r_state;
        w_lc_nxt    = r_lc;
        w_ec_nxt    = r_ec;
        if (flush) begin
            w_state_nxt = ST_LOAD;
            w_lc_nxt    = 4'd0;
            w_ec_nxt    = 6'd0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (in_valid) begin
                        // 4-bit count wraps to 0 on the 16th word
                        w_lc_nxt = r_lc + 4'd1;
                        if (r_lc == 4'd15) begin
                            w_state_nxt = ST_EMIT;
                            w_ec_nxt    = 6'd0;
                        end else begin
                            w_state_nxt = ST_LOAD;
                        end
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        w_ec_nxt = r_ec + 6'd1;
                        if (r_ec == 6'd63) begin
                            w_state_nxt = ST_LOAD;
                            w_lc_nxt    = 4'd0;
                            w_ec_nxt    = 6'd0;
                        end else begin
                            w_state_nxt = ST_EMIT;
                        end
                    end else begin
                        w_state_nxt = ST_EMIT;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOAD;
                    w_lc_nxt    = 4'd0;
                    w_ec_nxt    = 6'd0;
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state <= ST_LOAD;
            r_lc    <= 4'd0;
            r_ec    <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lc    <= w_lc_nxt;
            r_ec    <= w_ec_nxt;
        end
    end

    // Sliding window: shift left on either handshake, refill slot 15 with
    // the incoming word (LOAD) or the freshly expanded word (EMIT).
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'h0000_0000;
            end
        end else if (w_in_hs || w_out_hs) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_in_hs ? in_word : w_new;
        end else begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= r_win[i];
            end
        end
    end

endmodule
